// File: rtl/tt_puf_pkg.sv
`timescale 1ns/1ps
// Shared types, constants and helpers for the tt_um_puf ring-oscillator PUF tile.
package tt_puf_pkg;

  localparam int RO_IDX_W      = 4;
  localparam int SETTLE_CYCLES = 4;
  localparam int CLEAR_CYCLES  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } puf_state_e;

  typedef struct packed {
    logic        clipped;
    logic [15:0] value;
  } sat16_t;

  // Clamp a 17-bit signed difference into the 16-bit signed output range.
  function automatic sat16_t sat_diff16(input logic signed [16:0] d);
    sat16_t r;
    if (d > 17'sd32767) begin
      r.clipped = 1'b1;
      r.value   = 16'h7FFF;
    end else if (d < -17'sd32768) begin
      r.clipped = 1'b1;
      r.value   = 16'h8000;
    end else begin
      r.clipped = 1'b0;
      r.value   = d[15:0];
    end
    return r;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/puf_ro_counter.sv
`timescale 1ns/1ps
// One enable-gated ring oscillator feeding a saturating edge counter with async clear.
// SYNTHESIS selects the real NAND/inverter loop; otherwise a timed behavioural model is used.
module puf_ro_counter #(
  parameter int IDX              = 0,
  parameter int RO_STAGES        = 5,
  parameter int CNT_W            = 16,
  parameter int SIM_HALF_BASE_PS = 1000,
  parameter int SIM_HALF_STEP_PS = 100
) (
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic ro_clk;

`ifdef SYNTHESIS
  (* keep = "true", dont_touch = "true" *) logic [RO_STAGES-1:0] stage;

  assign stage[0] = ~(en & stage[RO_STAGES-1]);
  for (genvar i = 1; i < RO_STAGES; i++) begin : g_inv
    assign stage[i] = ~stage[i-1];
  end
  // Inverted tap so a disabled loop parks the counter clock low.
  assign ro_clk = ~stage[RO_STAGES-1];
`else
  localparam real HALF_NS      = real'(SIM_HALF_BASE_PS + IDX * SIM_HALF_STEP_PS) / 1000.0;
  localparam bit  LOOP_INVERTS = (RO_STAGES % 2) == 1;

  logic ro_q;

  // An even-stage loop would latch instead of oscillating, so it never toggles here either.
  always begin : sim_ro
    if (en !== 1'b1) begin
      ro_q = 1'b0;
      wait (en === 1'b1);
    end
    #(HALF_NS);
    ro_q = (en === 1'b1 && LOOP_INVERTS) ? ~ro_q : 1'b0;
  end

  assign ro_clk = ro_q;
`endif

  always_ff @(posedge ro_clk or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tt_um_puf.sv
`timescale 1ns/1ps
// tt_um_puf: RO-PUF tile comparing edge counts of two challenge-selected ring oscillators.
// Define PUF_MAJORITY_EN to run three measurements per start and vote on the response.
module tt_um_puf
  import tt_puf_pkg::*;
#(
  parameter int NUM_RO           = 16,
  parameter int RO_STAGES        = 5,
  parameter int CNT_W            = 16,
  parameter int WIN_DEFAULT      = 1024,
  parameter int SIM_HALF_BASE_PS = 1000,
  parameter int SIM_HALF_STEP_PS = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  ui_in,
  input  logic [7:0]  uio_in,
  input  logic [15:0] Uin,
  output logic [7:0]  uo_out,
  output logic [7:0]  uio_out,
  output logic [7:0]  uio_oe,
  output logic [15:0] Uout
);

  puf_state_e          state;
  logic [2:0]          start_sync;
  logic                start_rise;
  logic                accept;
  logic [15:0]         phase_cnt;
  logic [15:0]         win_len;
  logic [15:0]         win_sel;
  logic [RO_IDX_W-1:0] idx_a;
  logic [RO_IDX_W-1:0] idx_b;
  logic                run_en;
  logic                cnt_clr;
  logic                response_q;
  logic                done_q;
  logic                busy_q;
  logic                sat_q;
  logic [15:0]         uout_q;
  logic [NUM_RO-1:0]   ro_en;
  logic [CNT_W-1:0]    cnt [NUM_RO];
  logic [CNT_W-1:0]    cnt_a;
  logic [CNT_W-1:0]    cnt_b;
  logic signed [16:0]  diff;
  sat16_t              diff_sat;
  logic                a_wins;
  logic                cnt_full;
  logic                unused_uio;

`ifdef PUF_MAJORITY_EN
  logic [1:0] run_idx;
  logic [1:0] votes;
`endif

  assign unused_uio = &{1'b0, uio_in[7:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_sync <= '0;
    end else begin
      start_sync <= {start_sync[1:0], uio_in[0]};
    end
  end

  assign start_rise = start_sync[1] & ~start_sync[2];
  assign accept     = start_rise & ena & ((state == S_IDLE) || (state == S_DONE));
  assign win_sel    = (Uin == 16'd0) ? 16'(WIN_DEFAULT) : Uin;

  // Only the two challenged oscillators run, and never while the tile is deselected.
  always_comb begin
    ro_en = '0;
    if (run_en && ena) begin
      ro_en[idx_a] = 1'b1;
      ro_en[idx_b] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_RO; i++) begin : g_ro
    puf_ro_counter #(
      .IDX              (i),
      .RO_STAGES        (RO_STAGES),
      .CNT_W            (CNT_W),
      .SIM_HALF_BASE_PS (SIM_HALF_BASE_PS),
      .SIM_HALF_STEP_PS (SIM_HALF_STEP_PS)
    ) u_ro (
      .en    (ro_en[i]),
      .clr   (cnt_clr),
      .count (cnt[i])
    );
  end

  // Counts are only read in CAPTURE, after SETTLE has let the RO-domain counters stop.
  assign cnt_a    = cnt[idx_a];
  assign cnt_b    = cnt[idx_b];
  assign diff     = $signed({1'b0, cnt_a}) - $signed({1'b0, cnt_b});
  assign diff_sat = sat_diff16(diff);
  assign a_wins   = cnt_a > cnt_b;
  assign cnt_full = (&cnt_a) | (&cnt_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      phase_cnt  <= '0;
      win_len    <= '0;
      idx_a      <= '0;
      idx_b      <= '0;
      run_en     <= 1'b0;
      cnt_clr    <= 1'b1;
      response_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      sat_q      <= 1'b0;
      uout_q     <= '0;
`ifdef PUF_MAJORITY_EN
      run_idx    <= '0;
      votes      <= '0;
`endif
    end else if (!ena && busy_q) begin
      state  <= S_IDLE;
      run_en <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            idx_a     <= ui_in[3:0];
            idx_b     <= ui_in[7:4];
            win_len   <= win_sel;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
            cnt_clr   <= 1'b1;
            phase_cnt <= 16'(CLEAR_CYCLES - 1);
            state     <= S_CLEAR;
`ifdef PUF_MAJORITY_EN
            run_idx   <= '0;
`endif
          end
        end
        S_CLEAR: begin
          if (phase_cnt == 16'd0) begin
            cnt_clr   <= 1'b0;
            run_en    <= 1'b1;
            phase_cnt <= win_len - 16'd1;
            state     <= S_RUN;
          end else begin
            phase_cnt <= phase_cnt - 16'd1;
          end
        end
        S_RUN: begin
          if (phase_cnt == 16'd0) begin
            run_en    <= 1'b0;
            phase_cnt <= 16'(SETTLE_CYCLES - 1);
            state     <= S_SETTLE;
          end else begin
            phase_cnt <= phase_cnt - 16'd1;
          end
        end
        S_SETTLE: begin
          if (phase_cnt == 16'd0) begin
            state <= S_CAPTURE;
          end else begin
            phase_cnt <= phase_cnt - 16'd1;
          end
        end
        S_CAPTURE: begin
`ifdef PUF_MAJORITY_EN
          if (run_idx != 2'd2) begin
            votes     <= {votes[0], a_wins};
            run_idx   <= run_idx + 2'd1;
            cnt_clr   <= 1'b1;
            phase_cnt <= 16'(CLEAR_CYCLES - 1);
            state     <= S_CLEAR;
          end else begin
            response_q <= maj3(votes[1], votes[0], a_wins);
            uout_q     <= diff_sat.value;
            sat_q      <= cnt_full | diff_sat.clipped;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state      <= S_DONE;
          end
`else
          response_q <= a_wins;
          uout_q     <= diff_sat.value;
          sat_q      <= cnt_full | diff_sat.clipped;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state      <= S_DONE;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign uo_out  = {idx_a, sat_q, busy_q, done_q, response_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
  assign Uout    = uout_q;

endmodule

// File: tb/tb_tt_um_puf.sv
`timescale 1ns/1ps
// tb_tt_um_puf: directed self-checking bench for the tt_um_puf RO-PUF tile.
module tb_tt_um_puf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [7:0]  ui_in;
  logic [7:0]  uio_in;
  logic [15:0] Uin;
  logic [7:0]  uo_out;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;
  logic [15:0] Uout;

  int vectors     = 0;
  int miscompares = 0;
  int cyc;

  tt_um_puf dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .Uin     (Uin),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .Uout    (Uout)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_near(input string tag, input int observed, input int expected,
                            input int tol);
    logic in_range;
    vectors++;
    in_range = (observed >= expected - tol) && (observed <= expected + tol);
    assert (in_range === 1'b1) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d +/- %0d", tag, observed, expected, tol);
    end
  endtask

  // Pulse start with a challenge/window and wait (bounded) for done; optionally re-pulse mid-run.
  task automatic apply_stimulus(input logic [7:0] challenge, input logic [15:0] window,
                                input int retrig_at, input int budget, output int cycles);
    bit got;
    got    = 1'b0;
    cycles = 0;
    @(negedge clk);
    ui_in  = challenge;
    Uin    = window;
    uio_in = 8'h01;
    while (!got && cycles < budget) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (cycles == 3) begin
        check_output("done_clear_on_accept", uo_out[1], 1'b0);
        check_output("busy_after_accept", uo_out[2], 1'b1);
      end
      if (cycles == 4) uio_in = 8'h00;
      if (retrig_at > 0 && cycles == retrig_at) uio_in = 8'h01;
      if (retrig_at > 0 && cycles == retrig_at + 4) uio_in = 8'h00;
      if (cycles > 3 && uo_out[1]) got = 1'b1;
    end
    check_output("done_seen", 32'(got), 32'd1);
  endtask

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    Uin    = 16'h0000;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_uo_out", uo_out, 8'h00);
    check_output("reset_Uout", Uout, 16'h0000);
    check_output("reset_uio_oe", uio_oe, 8'h00);
    check_output("reset_uio_out", uio_out, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] A=0 B=15 default window");
    apply_stimulus(8'hF0, 16'h0000, 0, 1100, cyc);
    check_output("latency_default", cyc, 1034);
    check_output("resp_f0", uo_out[0], 1'b1);
    check_near("uout_f0", int'($signed(Uout)), 3072, 4);
    check_output("sat_f0", uo_out[3], 1'b0);
    check_output("busy_done_f0", uo_out[2], 1'b0);
    check_output("tag_f0", uo_out[7:4], 4'h0);

    $display("[TB] swapped challenge A=15 B=0");
    apply_stimulus(8'h0F, 16'h0000, 0, 1100, cyc);
    check_output("resp_0f", uo_out[0], 1'b0);
    check_near("uout_0f", int'($signed(Uout)), -3072, 4);
    check_output("tag_0f", uo_out[7:4], 4'hF);

    $display("[TB] tie A=B=3");
    apply_stimulus(8'h33, 16'h0000, 0, 1100, cyc);
    check_output("uout_tie", Uout, 16'h0000);
    check_output("resp_tie", uo_out[0], 1'b0);
    check_output("sat_tie", uo_out[3], 1'b0);
    check_output("tag_tie", uo_out[7:4], 4'h3);

    $display("[TB] short window A=0 B=1 Uin=100");
    apply_stimulus(8'h10, 16'd100, 0, 200, cyc);
    check_output("latency_short", cyc, 110);
    check_near("uout_short", int'($signed(Uout)), 45, 4);
    check_output("resp_short", uo_out[0], 1'b1);

    $display("[TB] start re-pulsed while busy");
    apply_stimulus(8'hF0, 16'h0000, 100, 1100, cyc);
    check_output("latency_retrig", cyc, 1034);
    check_near("uout_retrig", int'($signed(Uout)), 3072, 4);
    check_output("resp_retrig", uo_out[0], 1'b1);

    $display("[TB] ena dropped mid-run");
    @(negedge clk);
    ui_in  = 8'h0F;
    Uin    = 16'h0000;
    uio_in = 8'h01;
    repeat (3) @(negedge clk);
    check_output("busy_before_abort", uo_out[2], 1'b1);
    uio_in = 8'h00;
    repeat (200) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    check_output("busy_after_abort", uo_out[2], 1'b0);
    check_output("done_after_abort", uo_out[1], 1'b0);
    check_output("resp_kept_abort", uo_out[0], 1'b1);
    check_near("uout_kept_abort", int'($signed(Uout)), 3072, 4);
    ena = 1'b1;
    repeat (20) @(negedge clk);
    check_output("idle_after_abort", uo_out[2:1], 2'b00);

    $display("[TB] reset asserted mid-run");
    ui_in  = 8'hF0;
    uio_in = 8'h01;
    repeat (5) @(negedge clk);
    uio_in = 8'h00;
    repeat (300) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("midreset_uo_out", uo_out, 8'h00);
    check_output("midreset_Uout", Uout, 16'h0000);
    check_output("midreset_uio_oe", uio_oe, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] A saturates, positive clip");
    apply_stimulus(8'hF0, 16'd15000, 0, 15100, cyc);
    check_output("uout_clip_pos", Uout, 16'h7FFF);
    check_output("sat_clip_pos", uo_out[3], 1'b1);
    check_output("resp_clip_pos", uo_out[0], 1'b1);

    $display("[TB] B saturates, negative clip");
    apply_stimulus(8'h0F, 16'd15000, 0, 15100, cyc);
    check_output("uout_clip_neg", Uout, 16'h8000);
    check_output("sat_clip_neg", uo_out[3], 1'b1);
    check_output("resp_clip_neg", uo_out[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
